char_buf_arbiter: RTL
=====================

CHAR_BUF_ARBITER -- requirements
Module: char_buf_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 12, char-buffer address {h_char[6:0], v_char[4:0]}; DATA_W, default 32, entry {frontcolor, backcolor, char}; FIFO_DEPTH, default 4, write-queue entries; STARVE_LIMIT, default 16, cycles a queued write may wait.
REQ-002 SHALL have ports: clock  in  1  sole clock; reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: wr_valid  in  1  CPU write request; wr_ready  out  1  queue can accept; wr_addr  in  ADDR_W; wr_data  in  DATA_W.
REQ-004 SHALL have ports: rd_valid  in  1  VGA fetch request; rd_ready  out  1  fetch issued this cycle; rd_addr  in  ADDR_W; rd_data  out  DATA_W; rd_data_valid  out  1.
REQ-005 SHALL have ports: mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W (single-port RAM, 1-cycle synchronous read).
REQ-006 SHALL have ports: fifo_level  out  clog2(FIFO_DEPTH)+1  queued writes; forced_cnt  out  16  forced-write count.

Function
REQ-007 SHALL push {wr_addr, wr_data} on a clock edge where wr_valid && wr_ready; wr_ready = !full, independent of any same-cycle pop.
REQ-008 SHALL grant the RAM port to exactly one party per cycle, in priority order: forced write, read, normal write, none.
REQ-009 Read grant SHALL drive mem_addr = rd_addr, mem_we = 0, rd_ready = 1; rd_data = mem_rdata with rd_data_valid = 1 exactly one cycle later.
REQ-010 Write grant SHALL drive mem_addr/mem_wdata from the FIFO head, mem_we = 1, and pop the head at the same edge.
REQ-011 With neither grant active, mem_we SHALL be 0 and mem_addr SHALL hold its previous value.
REQ-012 The FSM SHALL use states S_IDLE (queue empty), S_PEND (queue non-empty, waiting), and S_FORCE (one forced-write cycle). Transitions: S_IDLE->S_PEND on push; S_PEND->S_IDLE when the last entry pops with no push; S_PEND->S_FORCE when the wait counter reaches STARVE_LIMIT; S_FORCE->S_PEND if entries remain, else S_IDLE.
REQ-013 The wait counter SHALL increment each cycle the queue is non-empty and the head is not popped, clear on any pop or when empty, and saturate at STARVE_LIMIT.
REQ-014 In S_FORCE, rd_ready SHALL be 0 even if rd_valid = 1; the requester holds rd_addr, and the read is granted in the following cycle.
REQ-015 forced_cnt SHALL increment on every S_FORCE entry and saturate at 16'hFFFF.
REQ-016 A simultaneous push and pop SHALL leave fifo_level unchanged; a push to a full queue SHALL be impossible (wr_ready = 0).
REQ-017 Reads SHALL NOT be forwarded from queued writes; a read may return stale data until the write drains.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FIFO_DEPTH SHALL be a power of two.

Reset
REQ-019 On reset_n low, asynchronously: queue emptied (pending writes discarded), state = S_IDLE, wait counter = 0, forced_cnt = 0, rd_data_valid = 0, mem_we = 0, mem_addr = 0, rd_ready = 0, wr_ready = 1 once released.
REQ-020 A read issued in the cycle before reset SHALL produce no rd_data_valid after reset.

Structure
REQ-021 State enum, default parameters, and the entry type {addr, data} SHALL live in package char_arb_pkg.
REQ-022 The write queue SHALL be a sub-module char_wr_fifo (push/pop/full/empty/level); arbitration and the FSM stay in char_buf_arbiter.

Verification
REQ-023 Idle read: rd_valid = 1, rd_addr = 12'h0A5, RAM holds 32'h00F0_0F41 -> rd_ready = 1 in the same cycle; rd_data = 32'h00F0_0F41 with rd_data_valid = 1 one cycle later.
REQ-024 Write drain: 4 back-to-back writes to 12'h001..12'h004 with rd_valid = 0 -> wr_ready = 0 after the 4th if no pop occurred; all four mem_we pulses occur in order; fifo_level returns to 0.
REQ-025 Starvation: one queued write with rd_valid held at 1 continuously -> exactly one forced write after STARVE_LIMIT = 16 waiting cycles; rd_ready = 0 in that cycle only; forced_cnt = 1.
REQ-026 Simultaneous events: full queue, with a pop and wr_valid in the same cycle -> no push that cycle (wr_ready = 0); push accepted the next cycle; fifo_level = 4.
REQ-027 Reset mid-operation: reset_n low with 3 queued writes and a read in flight -> fifo_level = 0, no mem_we, and no rd_data_valid after release.

Source files
------------

// File: rtl/char_arb_pkg.sv
// Shared types and defaults for the character-buffer RAM arbiter.
// The queued-write entry carries the default address/data widths.
package char_arb_pkg;

   localparam int ADDR_W_DEF       = 12;
   localparam int DATA_W_DEF       = 32;
   localparam int FIFO_DEPTH_DEF   = 4;
   localparam int STARVE_LIMIT_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PEND  = 2'd1,
      S_FORCE = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } char_entry_t;

   localparam int ENTRY_W = $bits(char_entry_t);

endpackage

// File: rtl/char_wr_fifo.sv
// CPU write queue: power-of-two ring buffer with occupancy count.
import char_arb_pkg::*;

module char_wr_fifo #(
   parameter  int DEPTH = FIFO_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               push_i,
   input  logic [ENTRY_W-1:0] push_data_i,
   input  logic               pop_i,
   output logic [ENTRY_W-1:0] pop_data_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [LVL_W-1:0]   level_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic               do_push, do_pop;

   assign full_o     = (level_q == LVL_W'(DEPTH));
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/char_buf_arbiter.sv
// Shares one single-port character RAM between VGA fetches and queued CPU
// writes; a write waiting too long gets one forced cycle ahead of reads.
import char_arb_pkg::*;

module char_buf_arbiter #(
   parameter  int ADDR_W       = ADDR_W_DEF,
   parameter  int DATA_W       = DATA_W_DEF,
   parameter  int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
   localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1,
   localparam int WAIT_W       = $clog2(STARVE_LIMIT + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [LVL_W-1:0]  fifo_level,
   output logic [15:0]       forced_cnt
);

   arb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [15:0]       forced_q, forced_d;
   logic [ADDR_W-1:0] addr_q;
   logic              rvalid_q;

   char_entry_t push_entry, head_entry;
   logic        full, empty, push, pop, last_pop;
   logic        force_gnt, rd_gnt, wr_gnt;

   assign push_entry = '{addr: wr_addr, data: wr_data};
   assign wr_ready   = !full;
   assign push       = wr_valid && !full;

   char_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .pop_data_o  (head_entry),
      .full_o      (full),
      .empty_o     (empty),
      .level_o     (fifo_level)
   );

   // Reads are masked while reset is held so the RAM port stays quiet.
   always_comb begin
      force_gnt = (state_q == S_FORCE) && !empty;
      rd_gnt    = reset_n && rd_valid && (state_q != S_FORCE);
      wr_gnt    = !rd_valid && (state_q != S_FORCE) && !empty;
      pop       = force_gnt || wr_gnt;
      last_pop  = pop && (fifo_level == LVL_W'(1)) && !push;
   end

   assign rd_ready      = rd_gnt;
   assign mem_we        = pop;
   assign mem_wdata     = head_entry.data;
   assign mem_addr      = pop ? head_entry.addr : (rd_gnt ? rd_addr : addr_q);
   assign rd_data       = mem_rdata;
   assign rd_data_valid = rvalid_q;
   assign forced_cnt    = forced_q;

   always_comb begin
      wait_d = wait_q;
      if (empty || pop)                           wait_d = '0;
      else if (wait_q != WAIT_W'(STARVE_LIMIT))   wait_d = wait_q + WAIT_W'(1);
   end

   always_comb begin
      state_d  = state_q;
      forced_d = forced_q;
      case (state_q)
         S_IDLE:  if (push) state_d = S_PEND;
         S_PEND: begin
            if (wait_d == WAIT_W'(STARVE_LIMIT)) state_d = S_FORCE;
            else if (last_pop)                   state_d = S_IDLE;
         end
         S_FORCE: state_d = (last_pop || (empty && !push)) ? S_IDLE : S_PEND;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_FORCE && state_q != S_FORCE && forced_q != 16'hFFFF)
         forced_d = forced_q + 16'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         wait_q   <= '0;
         forced_q <= '0;
         addr_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         forced_q <= forced_d;
         addr_q   <= mem_addr;
         rvalid_q <= rd_gnt;
      end
   end

endmodule
